// File: rtl/spi_slave.sv
// SPI mode-0 responder: synchronizes the initiator pins into clk, shifts words
// MSB-first in both directions and hands them to/from local logic.
module spi_slave #(
  parameter int                W_Data    = 8,
  parameter int                W_Counter = 4,
  parameter logic [W_Data-1:0] FILL      = {W_Data{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              MOSI_in,
  output logic              MISO_out,
  output logic              MISO_oe,
  input  logic [W_Data-1:0] data_to_transmit,
  input  logic              data_transmit_valid,
  output logic              transmit_ready,
  output logic [W_Data-1:0] data_in,
  output logic              data_in_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam logic [W_Counter-1:0] LAST_BIT = W_Counter'(W_Data - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0]           sclk_sync_q;
  logic [2:0]           cs_sync_q;
  logic [1:0]           mosi_sync_q;
  logic [1:0]           settle_q;
  logic                 armed_q;

  state_t               state_q;
  logic [W_Counter-1:0] bit_cnt_q;
  logic [W_Data-1:0]    tx_shift_q;
  logic [W_Data-1:0]    rx_shift_q;
  logic [W_Data-1:0]    data_in_q;
  logic                 data_in_valid_q;
  logic                 tx_underrun_q;
  logic                 oe_q;
  logic                 busy_q;
  logic [W_Data-1:0]    buf_q;
  logic                 ready_q;

  logic                 sclk_rise;
  logic                 sclk_fall;
  logic                 cs_fall;
  logic                 cs_rise;
  logic                 mosi_bit;
  logic                 start_en;
  logic                 word_done;
  logic                 load_en;
  logic                 buf_wr;
  logic [W_Data-1:0]    load_word_d;

  always_comb begin
    sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
    cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    mosi_bit    = mosi_sync_q[1];
    start_en    = (state_q == IDLE) && armed_q && cs_fall;
    word_done   = (state_q == SHIFT) && !cs_rise && sclk_rise && (bit_cnt_q == LAST_BIT);
    load_en     = start_en || word_done;
    buf_wr      = data_transmit_valid && ready_q;
    load_word_d = ready_q ? FILL : buf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], MOSI_in};
    end
  end

  // A cs_n fall is only honoured once the real pin has been seen high after
  // reset, so a chip select already low at reset release cannot start a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      if ((settle_q == 2'd2) && cs_sync_q[1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  // A write can only land on an empty buffer, and a load only empties a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= {W_Data{1'b0}};
      ready_q <= 1'b1;
    end else if (buf_wr) begin
      buf_q   <= data_to_transmit;
      ready_q <= 1'b0;
    end else if (load_en && !ready_q) begin
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      bit_cnt_q       <= {W_Counter{1'b0}};
      tx_shift_q      <= {W_Data{1'b0}};
      rx_shift_q      <= {W_Data{1'b0}};
      data_in_q       <= {W_Data{1'b0}};
      data_in_valid_q <= 1'b0;
      tx_underrun_q   <= 1'b0;
      oe_q            <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      data_in_valid_q <= 1'b0;
      tx_underrun_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_en) begin
            tx_shift_q    <= load_word_d;
            tx_underrun_q <= ready_q;
            bit_cnt_q     <= {W_Counter{1'b0}};
            state_q       <= SHIFT;
            oe_q          <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            // tx_shift is cleared so MISO reads 0 while idle
            state_q    <= IDLE;
            bit_cnt_q  <= {W_Counter{1'b0}};
            tx_shift_q <= {W_Data{1'b0}};
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[W_Data-2:0], mosi_bit};
            if (bit_cnt_q == LAST_BIT) begin
              data_in_q       <= {rx_shift_q[W_Data-2:0], mosi_bit};
              data_in_valid_q <= 1'b1;
              bit_cnt_q       <= {W_Counter{1'b0}};
              tx_shift_q      <= load_word_d;
              tx_underrun_q   <= ready_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + W_Counter'(1);
            end
          end else if (sclk_fall && (bit_cnt_q != {W_Counter{1'b0}})) begin
            tx_shift_q <= {tx_shift_q[W_Data-2:0], 1'b0};
          end
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MISO_out       = tx_shift_q[W_Data-1];
  assign MISO_oe        = oe_q;
  assign busy           = busy_q;
  assign transmit_ready = ready_q;
  assign data_in        = data_in_q;
  assign data_in_valid  = data_in_valid_q;
  assign tx_underrun    = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: acts as the SPI initiator and checks words, pulses and
// tx buffering against a word-level model of the transfer rules.
module tb_spi_slave;

  localparam logic [7:0] FILL = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       MOSI_in;
  logic       MISO_out;
  logic       MISO_oe;
  logic [7:0] data_to_transmit;
  logic       data_transmit_valid;
  logic       transmit_ready;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       tx_underrun;
  logic       busy;

  spi_slave #(.W_Data(8), .W_Counter(4), .FILL(FILL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .spi_clk             (spi_clk),
    .spi_cs_n            (spi_cs_n),
    .MOSI_in             (MOSI_in),
    .MISO_out            (MISO_out),
    .MISO_oe             (MISO_oe),
    .data_to_transmit    (data_to_transmit),
    .data_transmit_valid (data_transmit_valid),
    .transmit_ready      (transmit_ready),
    .data_in             (data_in),
    .data_in_valid       (data_in_valid),
    .tx_underrun         (tx_underrun),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int n_chk   = 0;
  int n_fail  = 0;
  int dv_cnt  = 0;
  int ur_cnt  = 0;
  int exp_ur  = 0;

  logic [7:0] mo     [0:3];
  bit         wr_en  [0:3];
  logic [7:0] wr_val [0:3];

  // model of the one-entry tx buffer
  bit         model_full = 1'b0;
  logic [7:0] model_buf  = 8'h00;

  always @(negedge clk) begin
    if (data_in_valid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (tx_underrun === 1'b1)   ur_cnt <= ur_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_load(output logic [7:0] w);
    if (model_full) begin
      w = model_buf;
      model_full = 1'b0;
    end else begin
      w = FILL;
      exp_ur++;
    end
  endtask

  task automatic model_write(input logic [7:0] v);
    chk("ready_at_write", 32'(transmit_ready), 32'(!model_full));
    data_to_transmit    = v;
    data_transmit_valid = 1'b1;
    if (!model_full) begin
      model_buf  = v;
      model_full = 1'b1;
    end
  endtask

  task automatic write_word(input logic [7:0] v);
    model_write(v);
    @(negedge clk);
    data_transmit_valid = 1'b0;
  endtask

  // nw words with cs_n held low; the last word may be cut to nbits_last bits
  task automatic xfer(input int nw, input int nbits_last, input int half);
    logic [7:0] exp_w;
    logic [7:0] mi;
    logic [7:0] din0;
    int dv0, ur0, nb;
    dv0    = dv_cnt;
    ur0    = ur_cnt;
    din0   = data_in;
    exp_ur = 0;
    spi_cs_n = 1'b0;
    model_load(exp_w);
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? nbits_last : 8;
      mi = 8'h00;
      for (int b = 0; b < nb; b++) begin
        MOSI_in = mo[w][7-b];
        for (int c = 0; c < half; c++) begin
          if (c == 0 && b == 3 && wr_en[w]) model_write(wr_val[w]);
          @(negedge clk);
          data_transmit_valid = 1'b0;
        end
        if (w == 0 && b == 0) begin
          chk("oe_in_word", 32'(MISO_oe), 32'd1);
          chk("busy_in_word", 32'(busy), 32'd1);
          chk("ready_after_start", 32'(transmit_ready), 32'(!model_full));
          chk("underrun_at_start", 32'(ur_cnt - ur0), 32'(exp_ur));
        end
        mi[7-b] = MISO_out;
        spi_clk = 1'b1;
        wait_clk(half);
        spi_clk = 1'b0;
      end
      if (nb == 8) begin
        chk("miso_word", 32'(mi), 32'(exp_w));
        chk("data_in_word", 32'(data_in), 32'(mo[w]));
        chk("dv_count", 32'(dv_cnt - dv0), 32'(w + 1));
        model_load(exp_w);
      end else begin
        chk("miso_partial", 32'(mi >> (8 - nb)), 32'(exp_w >> (8 - nb)));
      end
    end
    wait_clk(half);
    spi_cs_n = 1'b1;
    wait_clk(8);
    chk("oe_after_cs", 32'(MISO_oe), 32'd0);
    chk("busy_after_cs", 32'(busy), 32'd0);
    chk("miso_idle", 32'(MISO_out), 32'd0);
    chk("underrun_count", 32'(ur_cnt - ur0), 32'(exp_ur));
    chk("dv_total", 32'(dv_cnt - dv0), 32'((nbits_last == 8) ? nw : 0));
    if (nbits_last != 8) chk("data_in_held", 32'(data_in), 32'(din0));
  endtask

  task automatic check_reset_values();
    chk("rst_miso", 32'(MISO_out), 32'd0);
    chk("rst_oe", 32'(MISO_oe), 32'd0);
    chk("rst_ready", 32'(transmit_ready), 32'd1);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_dv", 32'(data_in_valid), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int dv0, ur0, nw, half, k;
    rst = 1'b1;
    spi_clk = 1'b0;
    spi_cs_n = 1'b1;
    MOSI_in = 1'b0;
    data_to_transmit = 8'h00;
    data_transmit_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mo[i] = 8'h00;
      wr_en[i] = 1'b0;
      wr_val[i] = 8'h00;
    end
    wait_clk(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();

    // idle with cs_n high: nothing happens
    dv0 = dv_cnt;
    ur0 = ur_cnt;
    wait_clk(50);
    chk("idle_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("idle_underrun", 32'(ur_cnt - ur0), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_oe", 32'(MISO_oe), 32'd0);

    // preloaded word, spi_clk period 10 clk
    write_word(8'hA5);
    mo[0] = 8'h3C;
    xfer(1, 8, 5);
    wait_clk(4);

    // empty buffer: FILL goes out
    mo[0] = 8'hFF;
    xfer(1, 8, 5);
    wait_clk(4);

    // back-to-back words with a refill during the first
    write_word(8'h11);
    mo[0] = 8'h81; wr_en[0] = 1'b1; wr_val[0] = 8'h22;
    mo[1] = 8'h7E;
    xfer(2, 8, 5);
    wr_en[0] = 1'b0;
    wait_clk(4);

    // abort after 5 bits, then a clean word
    write_word(8'h6B);
    mo[0] = 8'hF0;
    xfer(1, 5, 5);
    wait_clk(4);
    mo[0] = 8'h55;
    xfer(1, 8, 5);
    wait_clk(4);

    // reset mid-word with cs_n low
    spi_cs_n = 1'b0;
    wait_clk(6);
    for (int b = 0; b < 3; b++) begin
      MOSI_in = b[0];
      wait_clk(5);
      spi_clk = 1'b1;
      wait_clk(5);
      spi_clk = 1'b0;
    end
    write_word(8'h99);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    model_full = 1'b0;
    @(negedge clk);
    check_reset_values();
    dv0 = dv_cnt;
    ur0 = ur_cnt;
    for (int b = 0; b < 8; b++) begin
      MOSI_in = 1'b1;
      wait_clk(5);
      spi_clk = 1'b1;
      wait_clk(5);
      spi_clk = 1'b0;
    end
    chk("post_rst_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("post_rst_underrun", 32'(ur_cnt - ur0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_oe", 32'(MISO_oe), 32'd0);
    spi_cs_n = 1'b1;
    wait_clk(8);
    write_word(8'hC3);
    mo[0] = 8'h5A;
    xfer(1, 8, 5);
    wait_clk(4);

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      nw = $urandom_range(1, 3);
      half = $urandom_range(4, 8);
      for (int i = 0; i < 4; i++) begin
        mo[i] = 8'($urandom);
        wr_en[i] = 1'($urandom);
        wr_val[i] = 8'($urandom);
      end
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) write_word(8'($urandom));
      xfer(nw, 8, half);
      wait_clk(4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) peripheral-side engine.
- It is the responder to the CPU-side SPI initiator: it receives the initiator's spi_clk, chip select and MOSI, shifts in words MSB-first and returns words on MISO, all in the local clk domain.
- Received words go to local logic with a one-cycle valid pulse.
- Transmit words come from local logic through a one-entry valid/ready buffer.

Parameters:
- W_Data, 8, word width in bits.
- W_Counter, 4, bit-counter width; must satisfy 2^W_Counter > W_Data.
- FILL, 0, word shifted out on MISO when no tx word is buffered.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active high.
- spi_clk  input  1  serial clock from the initiator; asynchronous to clk.
- spi_cs_n  input  1  chip select from the initiator, active low; asynchronous.
- MOSI_in  input  1  serial data from the initiator; asynchronous.
- MISO_out  output  1  serial data to the initiator.
- MISO_oe  output  1  output enable for the MISO pad driver.
- data_to_transmit  input  W_Data  next word to return on MISO.
- data_transmit_valid  input  1  data_to_transmit is valid.
- transmit_ready  output  1  tx buffer can accept a word.
- data_in  output  W_Data  last fully received word.
- data_in_valid  output  1  one-cycle pulse: data_in was updated.
- tx_underrun  output  1  one-cycle pulse: FILL was loaded because the buffer was empty.
- busy  output  1  chip select is asserted (synchronized).

Behaviour:
- Synchronization
  - spi_clk, spi_cs_n and MOSI_in each pass through a 2-flop synchronizer; a third flop holds the previous value for edge detection.
  - An action on a pin edge registers on the 3rd clk edge, counting the edge that first samples the new pin level.
  - spi_clk high and low phases must each be at least 4 clk periods.
- Reset (rst=1 at a clk edge), regardless of state:
  - MISO_out=0, MISO_oe=0, transmit_ready=1, data_in=0, data_in_valid=0, tx_underrun=0, busy=0.
  - Bit counter=0, tx buffer empty, state=IDLE.
  - Synchronizer flops reset to cs_n=1, spi_clk=0, mosi=0.
  - If cs_n is low when reset releases, the block stays in IDLE until a fresh cs_n falling edge is seen.
- State IDLE (MISO_oe=0, MISO_out=0):
  - On a synchronized cs_n falling edge: load tx_shift from the buffer if it is full (buffer becomes empty); otherwise load FILL and pulse tx_underrun.
  - Then set bit_cnt=0 and go to SHIFT.
- State SHIFT (MISO_oe=1, busy=1, MISO_out = tx_shift[W_Data-1]):
  - spi_clk rising edge: rx_shift shifts left with mosi in at the LSB; bit_cnt+1.
  - spi_clk rising edge with bit_cnt == W_Data-1:
    - data_in <= {rx_shift[W_Data-2:0], mosi}; data_in_valid=1 for one cycle.
    - bit_cnt <= 0; tx_shift is reloaded with the next word (buffer or FILL + tx_underrun), supporting back-to-back words while cs_n stays low.
  - spi_clk falling edge with bit_cnt != 0: tx_shift shifts left by one. With bit_cnt == 0 the MSB stays presented.
  - cs_n rising edge (synchronized) in any bit position: abort and go to IDLE. The partial rx word is discarded with no data_in_valid; data_in is unchanged; an already-loaded tx word is dropped.
  - cs_n rising and spi_clk edge detected in the same cycle: the cs_n rise wins and the spi_clk edge is ignored.
- Tx buffer
  - transmit_ready = buffer empty.
  - A write occurs when data_transmit_valid && transmit_ready.
  - A write and a load in the same cycle on an empty buffer: the load takes FILL (tx_underrun) and the write fills the buffer for the next word.
  - When the buffer is full, transmit_ready=0 and writes are ignored.
- data_in holds its value until the next completed word; there is no back-pressure, and local logic must capture it on the pulse.

Test Plan:
- Reset, then idle: MISO_oe=0, transmit_ready=1, data_in=0, busy=0 -> no pulses for 50 cycles with cs_n high.
- Preload 0xA5, master sends 0x3C (spi_clk period 10 clk) -> MISO bits 1,0,1,0,0,1,0,1 sampled on spi_clk rises; data_in=0x3C with a single data_in_valid pulse; transmit_ready=1 after cs_n fall.
- Empty buffer, master sends 0xFF -> MISO all 0 (FILL), tx_underrun one pulse at cs_n fall, data_in=0xFF.
- Back-to-back: preload 0x11, write 0x22 during word 1, cs_n held low for 16 bits, master sends 0x81 then 0x7E -> MISO returns 0x11 then 0x22; two data_in_valid pulses with data_in 0x81 then 0x7E.
- cs_n raised after 5 bits of 0xF0 -> no data_in_valid, data_in unchanged, MISO_oe=0; next full transfer of 0x55 gives data_in=0x55.
- rst asserted mid-word with cs_n low, then released -> all outputs at reset values; no activity until cs_n rises and falls again; the following transfer is correct.
